// File: rtl/board_scanner.sv
// Sweeps the 10x10 board RAM once per start request, tallying interior
// black/white/empty cells and flagging any border or interior wall-code violation.
module board_scanner #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] q,
    output logic [7:0] addr,
    output logic       rden,
    output logic       busy,
    output logic       done,
    output logic [6:0] black_count,
    output logic [6:0] white_count,
    output logic [6:0] empty_count,
    output logic       board_error
);

    localparam int unsigned L       = READ_LATENCY;
    localparam int unsigned AW      = 8;
    localparam int unsigned CW      = 7;
    localparam int unsigned RCW     = 4;
    localparam int unsigned LAST_AD = 99;
    localparam int unsigned EDGE_IX = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [RCW-1:0] r_row;
    logic [RCW-1:0] r_col;
    logic [L-1:0]   r_vld;
    logic [L-1:0]   r_bdr;

    logic w_border;
    logic w_pending;
    logic w_last_addr;

    assign w_border    = (r_row == RCW'(0)) || (r_row == RCW'(EDGE_IX)) ||
                         (r_col == RCW'(0)) || (r_col == RCW'(EDGE_IX));
    // Reads still in flight behind the one being accumulated this cycle.
    assign w_pending   = |(r_vld << 1);
    assign w_last_addr = (addr == AW'(LAST_AD));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_vld       <= '0;
            r_bdr       <= '0;
            addr        <= '0;
            rden        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            black_count <= '0;
            white_count <= '0;
            empty_count <= '0;
            board_error <= 1'b0;
        end else begin
            r_vld <= L'({r_vld, rden});
            r_bdr <= L'({r_bdr, w_border});

            // Oldest delay-line stage lines up with valid read data on q.
            if (r_vld[L-1]) begin
                if (r_bdr[L-1]) begin
                    if (q != 2'b11) begin
                        board_error <= 1'b1;
                    end
                end else begin
                    case (q)
                        2'b00:   empty_count <= empty_count + CW'(1);
                        2'b01:   black_count <= black_count + CW'(1);
                        2'b10:   white_count <= white_count + CW'(1);
                        default: board_error <= 1'b1;
                    endcase
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_SCAN;
                        addr        <= '0;
                        rden        <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        r_row       <= '0;
                        r_col       <= '0;
                        black_count <= '0;
                        white_count <= '0;
                        empty_count <= '0;
                        board_error <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_last_addr) begin
                        r_state <= S_DRAIN;
                        rden    <= 1'b0;
                    end else begin
                        addr <= addr + AW'(1);
                        if (r_col == RCW'(EDGE_IX)) begin
                            r_col <= '0;
                            r_row <= r_row + RCW'(1);
                        end else begin
                            r_col <= r_col + RCW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_pending) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
